// File: rtl/inst_fetch.sv
// inst_fetch: program counter owner and sequential 4-byte instruction fetcher
// with a credit-limited instruction buffer towards decode.
//
// Ports:
//   clock, rst_n                 clock and asynchronous active-low reset
//   imem_req_valid/ready/addr    fetch request to instruction memory
//   imem_rsp_valid/data          in-order instruction word responses
//   redirect_valid/pc            flush and restart fetch at a new PC
//   inst_valid/ready, inst,      instruction handshake to decode, with the
//   inst_pc                      PC the word was fetched from
//   fetch_cnt                    instructions delivered to decode
//
// Build option: IFU_FETCH_CNT_EN enables the fetch_cnt counter; without it
// fetch_cnt is tied to zero and no counter flops exist.
module inst_fetch #(
    parameter logic [63:0] PC_RESET   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic [63:0] fetch_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

    logic          r_run;
    logic [63:0]   r_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_qrd;
    logic [AW-1:0] r_qwr;
    logic [31:0]   r_data [FIFO_DEPTH];
    logic [63:0]   r_pcs  [FIFO_DEPTH];
    logic [63:0]   r_rq   [FIFO_DEPTH];

    logic          w_pop;
    logic          w_pop_eff;
    logic          w_acc;
    logic          w_push;
    logic [CW-1:0] w_used;

    assign inst_valid = r_count != '0;
    assign inst       = inst_valid ? r_data[r_rd] : '0;
    assign inst_pc    = inst_valid ? r_pcs[r_rd] : '0;
    assign w_pop      = inst_valid & inst_ready;
    assign w_pop_eff  = w_pop & ~redirect_valid;
    // A pop this cycle frees a buffer slot, so it counts as credit right away.
    assign w_used         = r_inflight + r_count - CW'(w_pop);
    assign imem_req_valid = r_run & ~redirect_valid & (w_used < CW'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_acc          = imem_req_valid & imem_req_ready;
    assign w_push         = imem_rsp_valid & (r_drop == '0) & ~redirect_valid;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_pc       <= PC_RESET;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_qrd      <= '0;
            r_qwr      <= '0;
        end else begin
            r_run      <= 1'b1;
            r_pc       <= redirect_valid ? {redirect_pc[63:2], 2'b00} : r_pc + (w_acc ? 64'd4 : 64'd0);
            r_inflight <= r_inflight + CW'(w_acc) - CW'(imem_rsp_valid);
            // Everything still outstanding after this cycle's response belongs
            // to the old stream and must be discarded.
            r_drop     <= redirect_valid ? r_inflight - CW'(imem_rsp_valid) :
                          (imem_rsp_valid && r_drop != '0) ? r_drop - CW'(1) : r_drop;
            r_count    <= redirect_valid ? '0 : r_count + CW'(w_push) - CW'(w_pop_eff);
            r_rd       <= redirect_valid ? '0 : r_rd + AW'(w_pop_eff);
            r_wr       <= redirect_valid ? '0 : r_wr + AW'(w_push);
            // Request-PC queue tracks every outstanding request, dropped or not.
            r_qwr      <= r_qwr + AW'(w_acc);
            r_qrd      <= r_qrd + AW'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_data[r_wr] <= imem_rsp_data;
            r_pcs[r_wr]  <= r_rq[r_qrd];
        end
        if (w_acc)
            r_rq[r_qwr] <= r_pc;
    end

`ifdef IFU_FETCH_CNT_EN
    logic [63:0] r_fetch_cnt;
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            r_fetch_cnt <= '0;
        else if (w_pop_eff)
            r_fetch_cnt <= r_fetch_cnt + 64'd1;
    end
    assign fetch_cnt = r_fetch_cnt;
`else
    assign fetch_cnt = '0;
`endif
endmodule
